// File: rtl/nf10_sram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nf10_sram_fifo_pkg
// Brief    : Shared constants, FSM encoding and round-robin helper for the
//            SRAM FIFO blocks.
// Revision : 1.0
// ============================================================================
package nf10_sram_fifo_pkg;

    localparam int C_DEFAULT_DATA_WIDTH  = 256;
    localparam int C_DEFAULT_STRB_WIDTH  = 32;
    localparam int C_DEFAULT_TUSER_WIDTH = 128;
    localparam int C_MAX_QUEUES          = 8;

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_SEND = 1'b1;

    // First index at or above ptr (wrapping at num) whose request bit is set.
    function automatic logic [2:0] rr_next(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input logic [3:0] num);
        logic [3:0] cand;
        logic       found;
        rr_next = ptr;
        found   = 1'b0;
        for (int k = 0; k < C_MAX_QUEUES; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= num) cand = cand - num;
            if (!found && (4'(k) < num) && req[cand[2:0]]) begin
                rr_next = cand[2:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/nf10_sram_fifo_out_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : nf10_sram_fifo_out_arbiter_if
// Brief    : AXI4-Stream bundle carrying C_LANES side-by-side streams.
// Revision : 1.0
// ============================================================================
interface nf10_sram_fifo_out_arbiter_if #(
    parameter int C_LANES            = 1,
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128
);
    logic [C_LANES*C_AXIS_DATA_WIDTH-1:0]   tdata;
    logic [C_LANES*C_AXIS_DATA_WIDTH/8-1:0] tstrb;
    logic [C_LANES*C_AXIS_TUSER_WIDTH-1:0]  tuser;
    logic [C_LANES-1:0]                     tvalid;
    logic [C_LANES-1:0]                     tready;
    logic [C_LANES-1:0]                     tlast;

    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/nf10_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : nf10_rr_select
// Brief    : Combinational round-robin priority search over C_NUM_QUEUES
//            requests starting at i_ptr.
// Revision : 1.0
// ============================================================================
module nf10_rr_select
    import nf10_sram_fifo_pkg::*;
#(
    parameter int C_NUM_QUEUES = 4,
    parameter int C_IDX_W      = 2
) (
    input  wire logic [C_NUM_QUEUES-1:0] i_req,
    input  wire logic [C_IDX_W-1:0]      i_ptr,
    output logic      [C_IDX_W-1:0]      o_grant,
    output logic                         o_valid
);
    logic [7:0] w_req_ext;
    logic [2:0] w_ptr_ext;
    logic [2:0] w_idx;

    always_comb begin
        w_req_ext                   = '0;
        w_req_ext[C_NUM_QUEUES-1:0] = i_req;
        w_ptr_ext                   = '0;
        w_ptr_ext[C_IDX_W-1:0]      = i_ptr;
    end

    assign w_idx   = rr_next(w_req_ext, w_ptr_ext, 4'(C_NUM_QUEUES));
    assign o_grant = C_IDX_W'(w_idx);
    assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/nf10_sram_fifo_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nf10_sram_fifo_out_arbiter
// Brief    : Packet-granular round-robin merge of the SRAM FIFO queue outputs
//            into one registered AXI4-Stream master.
// Revision : 1.0
// ============================================================================
module nf10_sram_fifo_out_arbiter
    import nf10_sram_fifo_pkg::*;
#(
    parameter int C_NUM_QUEUES       = 4,
    parameter int C_AXIS_DATA_WIDTH  = C_DEFAULT_DATA_WIDTH,
    parameter int C_AXIS_TUSER_WIDTH = C_DEFAULT_TUSER_WIDTH
) (
    input  wire logic                  aclk,
    input  wire logic                  aresetn,
    nf10_sram_fifo_out_arbiter_if.slave  s_axis,
    nf10_sram_fifo_out_arbiter_if.master m_axis,
    output logic [7:0]                 pkt_count,
    output logic                       busy
);
    localparam int C_IDX_W  = (C_NUM_QUEUES > 1) ? $clog2(C_NUM_QUEUES) : 1;
    localparam int C_STRB_W = C_AXIS_DATA_WIDTH / 8;

    logic [0:0]                    r_state, w_state_nxt;
    logic [C_IDX_W-1:0]            r_sel, w_sel_nxt;
    logic [C_IDX_W-1:0]            r_rr_ptr, w_rr_ptr_nxt;
    logic [C_IDX_W-1:0]            w_rr_grant;
    logic [C_IDX_W-1:0]            w_sel_inc;
    logic                          w_rr_valid;
    logic                          w_ready_sel;
    logic                          w_s_hs;
    logic                          w_sel_last;

    logic                          r_m_tvalid;
    logic                          r_m_tlast;
    logic [C_AXIS_DATA_WIDTH-1:0]  r_m_tdata;
    logic [C_STRB_W-1:0]           r_m_tstrb;
    logic [C_AXIS_TUSER_WIDTH-1:0] r_m_tuser;
    logic [7:0]                    r_pkt_count;

    nf10_rr_select #(
        .C_NUM_QUEUES (C_NUM_QUEUES),
        .C_IDX_W      (C_IDX_W)
    ) u_rr_select (
        .i_req   (s_axis.tvalid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_rr_grant),
        .o_valid (w_rr_valid)
    );

    // The granted queue may advance whenever the output register is empty or draining.
    assign w_ready_sel = !r_m_tvalid || m_axis.tready[0];
    assign w_sel_last  = s_axis.tlast[r_sel];
    assign w_s_hs      = (r_state == C_ST_SEND) && s_axis.tvalid[r_sel] && w_ready_sel;
    assign w_sel_inc   = (r_sel == C_IDX_W'(C_NUM_QUEUES - 1)) ? '0 : r_sel + 1'b1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= C_ST_IDLE;
            r_sel    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            C_ST_IDLE: begin
                if (w_rr_valid) begin
                    w_sel_nxt   = w_rr_grant;
                    w_state_nxt = C_ST_SEND;
                end
            end
            default: begin
                if (w_s_hs && w_sel_last) begin
                    w_rr_ptr_nxt = w_sel_inc;
                    w_state_nxt  = C_ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        s_axis.tready = '0;
        busy          = 1'b0;
        if (r_state == C_ST_SEND) begin
            s_axis.tready[r_sel] = w_ready_sel;
            busy                 = 1'b1;
        end
    end

    // Output register drains independently of the FSM.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tstrb  <= '0;
            r_m_tuser  <= '0;
        end else if (w_s_hs) begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_sel_last;
            r_m_tdata  <= s_axis.tdata[r_sel*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
            r_m_tstrb  <= s_axis.tstrb[r_sel*C_STRB_W +: C_STRB_W];
            r_m_tuser  <= s_axis.tuser[r_sel*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
        end else if (m_axis.tready[0]) begin
            r_m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pkt_count <= '0;
        end else if (r_m_tvalid && m_axis.tready[0] && r_m_tlast) begin
            r_pkt_count <= r_pkt_count + 8'd1;
        end
    end

    assign m_axis.tvalid = r_m_tvalid;
    assign m_axis.tlast  = r_m_tlast;
    assign m_axis.tdata  = r_m_tdata;
    assign m_axis.tstrb  = r_m_tstrb;
    assign m_axis.tuser  = r_m_tuser;
    assign pkt_count     = r_pkt_count;

endmodule
`default_nettype wire
